// File: rtl/tm11_dma.sv
// tm11_dma: NPR DMA engine for the TM11 tape controller.
// Moves 16-bit words between a small data FIFO and Unibus memory.
//   tomem=1 (tape read): ARM pushes words into the FIFO, the engine writes them to memory (DATO).
//   tomem=0 (tape write): the engine reads memory (DATI) into the FIFO, the ARM pops them.
// Ports:
//   CLOCK, RESET                  clock, async active-high reset
//   start/tomem/addr_in/bcnt_in   transfer setup, sampled on start while idle
//   fi_valid/fi_data/fi_ready     ARM -> FIFO push side (tomem=1)
//   fo_valid/fo_data/fo_ready     FIFO -> ARM pop side (tomem=0)
//   npr_out_h/npg_in_h            NPR request/grant
//   a_out_h/c_out_h/d_out_h       bus address/control/write data (zero when not mastering)
//   d_in_h, msyn_out_h, ssyn_in_h bus read data and handshake
//   busy/done/nxm                 status; nxm is sticky until the next start
//   cur_addr/cur_bcnt             live address and byte count for register readback
module tm11_dma #(
    parameter int FIFODEP = 4,    // power of two, at least 2
    parameter int TIMEOUT = 1000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        start,
    input  logic        tomem,
    input  logic [17:0] addr_in,
    input  logic [15:0] bcnt_in,
    input  logic        fi_valid,
    input  logic [15:0] fi_data,
    output logic        fi_ready,
    output logic        fo_valid,
    output logic [15:0] fo_data,
    input  logic        fo_ready,
    output logic        npr_out_h,
    input  logic        npg_in_h,
    output logic [17:0] a_out_h,
    output logic [1:0]  c_out_h,
    output logic [15:0] d_out_h,
    input  logic [15:0] d_in_h,
    output logic        msyn_out_h,
    input  logic        ssyn_in_h,
    output logic        busy,
    output logic        done,
    output logic        nxm,
    output logic [17:0] cur_addr,
    output logic [15:0] cur_bcnt
);
    localparam int AW = $clog2(FIFODEP);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_REQ, S_MSYN, S_WSSYN, S_REL, S_DONE
    } state_t;

    state_t        state, state_nx;
    logic          tomem_r;
    logic [17:0]   addr_r;
    logic [15:0]   bcnt_r;
    logic          nxm_r;
    logic [TW-1:0] tmo_cnt;

    logic [15:0]   mem [FIFODEP];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          full, empty, fifo_cond, flush, dma_xfer, push, pop, bus_en;
    logic [15:0]   push_data;

    assign full      = (cnt == (AW+1)'(FIFODEP));
    assign empty     = (cnt == '0);
    // Only the engine drains the FIFO in DATO mode and only the engine fills
    // it in DATI mode, so once this condition holds it stays true until the
    // engine itself moves a word; npr therefore never retracts before grant.
    assign fifo_cond = tomem_r ? !empty : !full;
    assign flush     = (state == S_IDLE) && start;
    assign dma_xfer  = (state == S_WSSYN) && ssyn_in_h;

    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign nxm       = nxm_r;
    assign cur_addr  = addr_r;
    assign cur_bcnt  = bcnt_r;

    assign fi_ready  = !full && tomem_r && busy;
    assign fo_valid  = !empty && !tomem_r;
    assign fo_data   = mem[rp];

    // Flush wins over any ARM handshake in the same cycle.
    assign push      = !flush && (tomem_r ? (fi_valid && fi_ready) : dma_xfer);
    assign pop       = !flush && (tomem_r ? dma_xfer : (fo_valid && fo_ready));
    assign push_data = tomem_r ? fi_data : d_in_h;

    // Bus outputs are driven only while this engine owns the bus.
    assign bus_en     = (state == S_MSYN) || (state == S_WSSYN);
    assign npr_out_h  = bus_en || ((state == S_REQ) && fifo_cond);
    assign msyn_out_h = (state == S_WSSYN);
    assign a_out_h    = bus_en ? addr_r : '0;
    assign c_out_h    = {bus_en && tomem_r, 1'b0};
    assign d_out_h    = (bus_en && tomem_r) ? mem[rp] : '0;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = (bcnt_in == '0) ? S_DONE : S_REQ;
            S_FILL:  if (fifo_cond) state_nx = S_REQ;
            S_REQ: begin
                if (!fifo_cond)    state_nx = S_FILL;
                else if (npg_in_h) state_nx = S_MSYN;
            end
            S_MSYN:  state_nx = S_WSSYN;   // one cycle of address setup before msyn
            S_WSSYN: begin
                if (ssyn_in_h)                          state_nx = S_REL;
                else if (tmo_cnt == TW'(TIMEOUT - 1))   state_nx = S_DONE;
            end
            S_REL: begin
                if (!ssyn_in_h)
                    state_nx = (bcnt_r == 16'o000000 || bcnt_r == 16'o000001) ? S_DONE : S_REQ;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            tomem_r <= 1'b0;
            addr_r  <= '0;
            bcnt_r  <= '0;
            nxm_r   <= 1'b0;
            tmo_cnt <= '0;
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            if (flush) begin
                tomem_r <= tomem;
                addr_r  <= addr_in & ~18'd1;
                bcnt_r  <= bcnt_in;
                nxm_r   <= 1'b0;
                wp      <= '0;
                rp      <= '0;
                cnt     <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (pop)  rp <= rp + 1'b1;
                cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            end

            if (state == S_MSYN)
                tmo_cnt <= '0;
            else if ((state == S_WSSYN) && !ssyn_in_h)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (dma_xfer) begin
                addr_r <= addr_r + 18'd2;
                // An odd count ends at -1; the last word goes whole and the count lands on zero.
                bcnt_r <= (bcnt_r == 16'hFFFF) ? 16'h0000 : bcnt_r + 16'd2;
            end

            if ((state == S_WSSYN) && !ssyn_in_h && (tmo_cnt == TW'(TIMEOUT - 1)))
                nxm_r <= 1'b1;
        end
    end

    // FIFO storage, no reset needed: occupancy is tracked by cnt.
    always_ff @(posedge CLOCK) begin
        if (push) mem[wp] <= push_data;
    end
endmodule

// File: tb/tb_tm11_dma.sv
module tb_tm11_dma;
    localparam int FIFODEP = 4;
    localparam int TIMEOUT = 16;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0, tomem = 1'b0;
    logic [17:0] addr_in = '0;
    logic [15:0] bcnt_in = '0;
    logic        fi_valid = 1'b0, fi_ready;
    logic [15:0] fi_data = '0;
    logic        fo_valid, fo_ready = 1'b0;
    logic [15:0] fo_data;
    logic        npr_out_h, npg_in_h = 1'b0;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    logic [15:0] d_out_h, d_in_h = '0;
    logic        msyn_out_h, ssyn_in_h = 1'b0;
    logic        busy, done, nxm;
    logic [17:0] cur_addr;
    logic [15:0] cur_bcnt;

    tm11_dma #(.FIFODEP(FIFODEP), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .start(start), .tomem(tomem),
        .addr_in(addr_in), .bcnt_in(bcnt_in),
        .fi_valid(fi_valid), .fi_data(fi_data), .fi_ready(fi_ready),
        .fo_valid(fo_valid), .fo_data(fo_data), .fo_ready(fo_ready),
        .npr_out_h(npr_out_h), .npg_in_h(npg_in_h),
        .a_out_h(a_out_h), .c_out_h(c_out_h), .d_out_h(d_out_h), .d_in_h(d_in_h),
        .msyn_out_h(msyn_out_h), .ssyn_in_h(ssyn_in_h),
        .busy(busy), .done(done), .nxm(nxm), .cur_addr(cur_addr), .cur_bcnt(cur_bcnt)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct { logic [17:0] addr; logic [1:0] ctl; logic [15:0] data; } bus_t;
    typedef struct {
        logic tm; logic [17:0] a; logic [15:0] bc; logic [15:0] w0; logic [15:0] w1;
        logic [17:0] ea; logic [15:0] eb;
    } vec_t;

    bus_t        bus_q[$];
    logic [15:0] fo_q[$];
    logic [15:0] fi_words[$];
    int          checks = 0, failures = 0;
    int          bus_cycles = 0, msyn_hi = 0;
    logic        slave_en = 1'b1;
    logic        msyn_q = 1'b0;
    logic [17:0] prev_a = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents seen by DATI: word at 0o1000 is 1, 0o1002 is 2, ...
    function automatic logic [15:0] mval(input logic [17:0] a);
        logic [17:0] d;
        d = a - 18'o001000;
        return d[16:1] + 16'd1;
    endfunction

    // Bus slave and arbiter: grant follows request, ssyn follows msyn.
    always @(negedge CLOCK) begin
        npg_in_h = npr_out_h;
        if (msyn_out_h && slave_en) begin
            if (c_out_h == 2'b00) d_in_h = mval(a_out_h);
            ssyn_in_h = 1'b1;
        end else if (!msyn_out_h) begin
            ssyn_in_h = 1'b0;
        end
    end

    // Bus monitor: each msyn rising edge is one bus cycle checked against the scoreboard.
    always @(negedge CLOCK) begin
        bus_t e;
        if (msyn_out_h) msyn_hi++;
        if (msyn_out_h && !msyn_q) begin
            bus_cycles++;
            if (bus_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL bus_extra: unexpected cycle at %o", a_out_h);
            end else begin
                e = bus_q.pop_front();
                chk("bus_addr", a_out_h, e.addr);
                chk("bus_setup", prev_a, e.addr);
                chk("bus_ctl", c_out_h, e.ctl);
                chk("bus_npr", npr_out_h, 1);
                if (e.ctl == 2'b10) chk("bus_wdata", d_out_h, e.data);
            end
        end
        msyn_q = msyn_out_h;
        prev_a = a_out_h;
    end

    task automatic pulse_start(input logic tm, input logic [17:0] a, input logic [15:0] bc);
        @(negedge CLOCK);
        start = 1'b1; tomem = tm; addr_in = a; bcnt_in = bc;
    endtask

    // Model: push the expected bus cycles and FIFO words, then kick the DUT.
    task automatic start_xfer(input logic tm, input logic [17:0] a, input logic [15:0] bc,
                              input logic [15:0] w0, input logic [15:0] w1);
        logic [17:0] ea;
        int n, c;
        bus_t e;
        ea = a & ~18'd1;
        c  = 65536 - int'(bc);
        n  = (bc == 16'd0) ? 0 : (c + 1) / 2;
        for (int i = 0; i < n; i++) begin
            e.addr = ea;
            e.ctl  = tm ? 2'b10 : 2'b00;
            e.data = (i == 0) ? w0 : w1 + 16'(i - 1);
            bus_q.push_back(e);
            if (tm) fi_words.push_back(e.data);
            else    fo_q.push_back(mval(ea));
            ea = ea + 18'd2;
        end
        pulse_start(tm, a, bc);
    endtask

    task automatic wait_done(input bit pop_en, input int budget, output int dcnt);
        int post;
        bit seen;
        logic [15:0] ev;
        dcnt = 0; post = 0; seen = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge CLOCK);
            start = 1'b0;
            if (done) begin dcnt++; seen = 1; end
            if (seen) post++;
            if (seen && post > 3 && fo_q.size() == 0) break;
            if (pop_en && fo_valid) begin
                if (fo_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL fo_extra: got %o", fo_data);
                end else begin
                    ev = fo_q.pop_front();
                    chk("fo_data", fo_data, ev);
                end
                fo_ready = 1'b1;
            end else begin
                fo_ready = 1'b0;
            end
            if (fi_words.size() > 0 && fi_ready) begin
                fi_valid = 1'b1; fi_data = fi_words.pop_front();
            end else begin
                fi_valid = 1'b0;
            end
        end
        fo_ready = 1'b0; fi_valid = 1'b0;
        if (!seen) begin
            checks++; failures++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic clear_q();
        bus_q.delete(); fo_q.delete(); fi_words.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int dc, m0, b0, waited, dn;

        tbl[0] = '{1'b0, 18'o001000, 16'hFFFA, 16'h0000, 16'h0000, 18'o001006, 16'h0000};
        // 16-bit payload: low 16 bits of 654321 octal
        tbl[1] = '{1'b1, 18'o002000, 16'hFFFD, 16'o123456, 16'o054321, 18'o002004, 16'h0000};
        tbl[2] = '{1'b0, 18'o777776, 16'hFFFC, 16'h0000, 16'h0000, 18'o000002, 16'h0000};
        tbl[3] = '{1'b0, 18'o177776, 16'hFFFC, 16'h0000, 16'h0000, 18'o200002, 16'h0000};
        tbl[4] = '{1'b1, 18'o004001, 16'hFFFE, 16'hBEEF, 16'h0000, 18'o004002, 16'h0000};
        tbl[5] = '{1'b0, 18'o000500, 16'h0000, 16'h0000, 16'h0000, 18'o000500, 16'h0000};
        tbl[6] = '{1'b1, 18'o003000, 16'hFFFF, 16'h1234, 16'h0000, 18'o003002, 16'h0000};
        tbl[7] = '{1'b1, 18'o010000, 16'hFFF8, 16'hA5A5, 16'h0001, 18'o010010, 16'h0000};

        // Reset state
        repeat (2) @(negedge CLOCK);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_nxm", nxm, 0);
        chk("rst_npr_msyn", {npr_out_h, msyn_out_h}, 0);
        chk("rst_bus", {a_out_h, c_out_h, d_out_h}, 0);
        chk("rst_cur", {cur_addr, cur_bcnt}, 0);
        chk("rst_fifo_hs", {fi_ready, fo_valid}, 0);
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK);

        // Table-driven transfers
        for (int i = 0; i < 8; i++) begin
            start_xfer(tbl[i].tm, tbl[i].a, tbl[i].bc, tbl[i].w0, tbl[i].w1);
            wait_done(1'b1, 400, dc);
            chk("done_pulses", dc, 1);
            chk("end_addr", cur_addr, tbl[i].ea);
            chk("end_bcnt", cur_bcnt, tbl[i].eb);
            chk("end_nxm", nxm, 0);
            chk("end_busy", busy, 0);
            chk("bus_left", bus_q.size(), 0);
            chk("idle_bus", {npr_out_h, msyn_out_h, a_out_h, c_out_h, d_out_h}, 0);
            clear_q();
        end

        // No slave: msyn held for TIMEOUT cycles, nxm set, counters frozen
        slave_en = 1'b0;
        bus_q.push_back('{18'o006000, 2'b00, 16'h0000});
        m0 = msyn_hi;
        pulse_start(1'b0, 18'o006000, 16'hFFFC);
        wait_done(1'b0, 200, dc);
        chk("nxm_done", dc, 1);
        chk("nxm_msyn_cycles", msyn_hi - m0, TIMEOUT);
        chk("nxm_flag", nxm, 1);
        chk("nxm_addr", cur_addr, 18'o006000);
        chk("nxm_bcnt", cur_bcnt, 16'hFFFC);
        chk("nxm_bus_left", bus_q.size(), 0);
        slave_en = 1'b1;
        repeat (5) @(negedge CLOCK);
        chk("nxm_sticky", nxm, 1);
        clear_q();

        // FIFO full: exactly FIFODEP reads, then npr held off until the ARM pops
        start_xfer(1'b0, 18'o020000, 16'hFFEC, 16'h0000, 16'h0000);
        @(negedge CLOCK); start = 1'b0;
        b0 = bus_cycles;
        repeat (60) @(negedge CLOCK);
        chk("full_cycles", bus_cycles - b0, FIFODEP);
        chk("full_npr", npr_out_h, 0);
        chk("full_busy", busy, 1);
        chk("full_fo_valid", fo_valid, 1);
        chk("full_nxm_cleared", nxm, 0);
        wait_done(1'b1, 600, dc);
        chk("full_done", dc, 1);
        chk("full_addr", cur_addr, 18'o020024);
        chk("full_bcnt", cur_bcnt, 16'h0000);
        clear_q();

        // start while busy is ignored
        start_xfer(1'b0, 18'o007000, 16'hFFFC, 16'h0000, 16'h0000);
        @(negedge CLOCK); start = 1'b0;
        @(negedge CLOCK);
        start = 1'b1; tomem = 1'b1; addr_in = 18'o000100; bcnt_in = 16'hFFFE;
        wait_done(1'b1, 400, dc);
        chk("busy_start_done", dc, 1);
        chk("busy_start_addr", cur_addr, 18'o007004);
        chk("busy_start_bcnt", cur_bcnt, 16'h0000);
        chk("busy_start_bus_left", bus_q.size(), 0);
        clear_q();

        // Reset while waiting for ssyn
        slave_en = 1'b0;
        start_xfer(1'b0, 18'o030000, 16'hFFFC, 16'h0000, 16'h0000);
        @(negedge CLOCK); start = 1'b0;
        waited = 0;
        while (!msyn_out_h && waited < 50) begin @(negedge CLOCK); waited++; end
        chk("rst_reach_wssyn", msyn_out_h, 1);
        repeat (3) @(negedge CLOCK);
        RESET = 1'b1;
        #1;
        chk("rst_mid_msyn", msyn_out_h, 0);
        chk("rst_mid_npr", npr_out_h, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_bus", {a_out_h, c_out_h}, 0);
        chk("rst_mid_cur", cur_addr, 0);
        dn = 0;
        repeat (3) begin @(negedge CLOCK); if (done) dn++; end
        RESET = 1'b0;
        slave_en = 1'b1;
        repeat (3) begin @(negedge CLOCK); if (done) dn++; end
        chk("rst_mid_no_done", dn, 0);
        clear_q();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tm11_dma.md
TM11_DMA -- requirements
Module: tm11_dma

Interface
REQ-001 SHALL have parameter FIFODEP, default 4 (power of two), meaning depth of the data word FIFO.
REQ-002 SHALL have parameter TIMEOUT, default 1000, meaning CLOCK cycles to wait for ssyn_in_h before flagging non-existent memory.
REQ-003 SHALL have ports (name direction width meaning):
 CLOCK  in  1  sole clock, all state on rising edge
 RESET  in  1  asynchronous, active-high reset
 start  in  1  one-cycle pulse, begin transfer (ignored unless idle)
 tomem  in  1  1 = tape read (FIFO -> memory), 0 = tape write (memory -> FIFO); sampled at start
 addr_in  in  18  starting byte address (mtc extension bits + mtcma), bit 0 ignored
 bcnt_in  in  16  two's-complement negative byte count (mtbrc)
 fi_valid, fi_data[15:00], fi_ready  in/in/out  ARM-side push into FIFO (tomem=1)
 fo_valid, fo_data[15:00], fo_ready  out/out/in  ARM-side pop from FIFO (tomem=0)
 npr_out_h  out  1  NPR bus request
 npg_in_h  in  1  NPR grant
 a_out_h  out  18  bus address
 c_out_h  out  2  bus control; 2'b10 = DATO, 2'b00 = DATI
 d_out_h  out  16  bus write data
 d_in_h  in  16  bus read data
 msyn_out_h  out  1  master sync
 ssyn_in_h  in  1  slave sync
 busy  out  1  transfer in progress
 done  out  1  one-cycle pulse at completion (normal or error)
 nxm  out  1  sticky non-existent-memory flag, cleared by start
 cur_addr  out  18  live address (to update mtcma/extension)
 cur_bcnt  out  16  live byte count (to update mtbrc)

Function
REQ-004 SHALL implement states IDLE, FILL, REQ, MSYN, WSSYN, REL, DONE.
REQ-005 IDLE: start -> load cur_addr = {addr_in[17:01],0}, cur_bcnt = bcnt_in, clear nxm, flush FIFO, busy = 1; next REQ if bcnt_in == 0 is false, else DONE.
REQ-006 REQ: tomem=1 SHALL wait for FIFO non-empty, tomem=0 for FIFO not full, before asserting npr_out_h; on npg_in_h -> MSYN.
REQ-007 MSYN: drive a_out_h = cur_addr, c_out_h, and (DATO) d_out_h = FIFO head, one cycle of address setup, then assert msyn_out_h -> WSSYN.
REQ-008 WSSYN: on ssyn_in_h, DATI SHALL push d_in_h into FIFO, DATO SHALL pop FIFO head; deassert msyn_out_h, npr_out_h -> REL; cur_addr += 2, cur_bcnt += 2.
REQ-009 WSSYN: if ssyn_in_h absent for TIMEOUT consecutive cycles, SHALL set nxm, deassert msyn_out_h/npr_out_h, leave cur_addr/cur_bcnt unchanged -> DONE.
REQ-010 REL: wait for ssyn_in_h low; then DONE if cur_bcnt == 0 or cur_bcnt == 16'o000001 (odd-count last word), else REQ.
REQ-011 Odd byte count SHALL transfer the final word whole and force cur_bcnt to 0.
REQ-012 cur_addr SHALL be 18-bit, carry from bit 15 propagating into 17:16; 18'o777776 + 2 wraps to 0 without error.
REQ-013 DONE: pulse done for one cycle, busy = 0 -> IDLE; for tomem=0, words already in FIFO remain poppable until next start.
REQ-014 FIFO: simultaneous push and pop in same cycle SHALL both succeed when not empty; fi_ready = not full and tomem=1 and busy; fo_valid = not empty and tomem=0.
REQ-015 start while busy SHALL be ignored.
REQ-016 Bus outputs a_out_h, c_out_h, d_out_h SHALL be 0 whenever npr_out_h is 0 and in IDLE.

Reset
REQ-017 RESET SHALL asynchronously force IDLE, busy = done = nxm = 0, npr_out_h = msyn_out_h = 0, a_out_h = c_out_h = d_out_h = 0, cur_addr = cur_bcnt = 0, FIFO empty, fi_ready = fo_valid = 0.
REQ-018 RESET mid-transfer (any state incl. WSSYN with msyn asserted) SHALL drop msyn_out_h and npr_out_h in the same cycle with no done pulse.

Verification
REQ-019 tomem=0, addr 0o1000, bcnt -6, memory 1/2/3 -> three DATI at 0o1000/1002/1004, fo_data 1,2,3, cur_bcnt 0, cur_addr 0o1006, one done pulse.
REQ-020 tomem=1, bcnt -3, push 0o123456,0o654321 -> two DATO, cur_bcnt 0, cur_addr start+4.
REQ-021 addr 18'o777776, bcnt -4 -> DATI at 777776 then 000000, no nxm.
REQ-022 no slave responding -> msyn held TIMEOUT cycles, nxm = 1, done pulse, cur_addr/cur_bcnt unchanged.
REQ-023 tomem=0 with fo_ready held 0, bcnt -20 -> exactly FIFODEP DATI cycles then npr held off until pop.
REQ-024 RESET asserted during WSSYN -> msyn_out_h, npr_out_h, busy 0 immediately, no done.
